// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: refill state
// encoding, address-field width helpers and ROM beat constants.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int BEAT_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_e;

  // Width of the word-offset field inside a line.
  function automatic int off_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  // Width of the line-index field.
  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  // Width of the tag: everything above offset and index, excluding the byte bits.
  function automatic int tag_bits(input int lines, input int line_words);
    return ADDR_W - 2 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill sequencer for icache_dm: state register, beat counter, line base
// latch, deferred fence and the ROM request/address handshake.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 start_base,
  input  logic                              fence_i,
  input  logic                              rom_ready,
  output state_e                            state,
  output logic [$clog2(LINE_WORDS)-1:0]     beat,
  output logic [ADDR_W-1:0]                 base,
  output logic                              beat_we,
  output logic                              last_beat,
  output logic                              inval_all,
  output logic                              rom_req,
  output logic [ADDR_W-1:0]                 rom_addr
);

  localparam int OFF_W = off_bits(LINE_WORDS);

  state_e             state_r;
  state_e             state_s;
  logic [OFF_W-1:0]   beat_r;
  logic [ADDR_W-1:0]  base_r;
  logic [ADDR_W-1:0]  rom_addr_r;
  logic               rom_req_r;
  logic               fence_pend_r;
  logic               last_s;

  assign last_s    = (beat_r == OFF_W'(LINE_WORDS - 1));
  assign state     = state_r;
  assign beat      = beat_r;
  assign base      = base_r;
  assign rom_req   = rom_req_r;
  assign rom_addr  = rom_addr_r;
  assign last_beat = last_s;
  assign beat_we   = (state_r == REFILL) && rom_ready;

  // A fence seen in IDLE clears at once; a deferred one clears as we re-enter IDLE,
  // which also drops the line that was just filled.
  always_comb begin
    inval_all = 1'b0;
    case (state_r)
      IDLE:      inval_all = fence_i;
      FILL_DONE: inval_all = fence_pend_r || fence_i;
      default:   inval_all = 1'b0;
    endcase
  end

  // Next-state selection for the refill sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = REFILL;
        else       state_s = IDLE;
      end
      REFILL: begin
        if (rom_ready && last_s) state_s = FILL_DONE;
        else                     state_s = REFILL;
      end
      FILL_DONE: state_s = IDLE;
      default:   state_s = IDLE;
    endcase
  end

  // State, beat counter, base latch, pending fence and ROM handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      beat_r       <= '0;
      base_r       <= '0;
      rom_req_r    <= 1'b0;
      rom_addr_r   <= '0;
      fence_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          fence_pend_r <= 1'b0;
          if (start) begin
            base_r     <= start_base;
            beat_r     <= '0;
            rom_req_r  <= 1'b1;
            rom_addr_r <= start_base;
          end
        end
        REFILL: begin
          if (fence_i) fence_pend_r <= 1'b1;
          if (rom_ready) begin
            beat_r <= beat_r + OFF_W'(1);
            if (last_s) rom_req_r  <= 1'b0;
            else        rom_addr_r <= rom_addr_r + 32'd4;
          end
        end
        FILL_DONE: fence_pend_r <= 1'b0;
        default: begin
          rom_req_r    <= 1'b0;
          fence_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits are served in the same
// cycle; misses refill a whole line beat-by-beat from the instruction ROM.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fence_i_i,
  output logic [31:0] inst_o,
  output logic        icache_ready_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_ready_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o
`endif
);

  localparam int OFF_W = off_bits(LINE_WORDS);
  localparam int IDX_W = idx_bits(LINES);
  localparam int TAG_W = tag_bits(LINES, LINE_WORDS);

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [WORD_W-1:0] data_r [LINES][LINE_WORDS];

  logic [OFF_W-1:0]  off_s;
  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  rf_idx_s;
  logic [TAG_W-1:0]  rf_tag_s;
  logic [31:0]       line_base_s;
  logic [31:0]       base_s;
  logic [OFF_W-1:0]  beat_s;
  state_e            state_s;
  logic              hit_s;
  logic              idle_s;
  logic              miss_s;
  logic              beat_we_s;
  logic              last_beat_s;
  logic              inval_all_s;
  logic              unused_s;

  assign off_s       = fetch_addr_i[2 +: OFF_W];
  assign idx_s       = fetch_addr_i[2 + OFF_W +: IDX_W];
  assign tag_s       = fetch_addr_i[31 -: TAG_W];
  assign line_base_s = {fetch_addr_i[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign rf_idx_s    = base_s[2 + OFF_W +: IDX_W];
  assign rf_tag_s    = base_s[31 -: TAG_W];
  assign unused_s    = ^{fetch_addr_i[1:0], base_s[OFF_W+1:0]};

  assign idle_s = (state_s == IDLE);
  assign hit_s  = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign miss_s = idle_s && fetch_req_i && !hit_s && !fence_i_i;

  icache_refill_fsm #(.LINE_WORDS(LINE_WORDS)) u_refill (
    .clk        (clk),
    .rst        (rst),
    .start      (miss_s),
    .start_base (line_base_s),
    .fence_i    (fence_i_i),
    .rom_ready  (rom_ready_i),
    .state      (state_s),
    .beat       (beat_s),
    .base       (base_s),
    .beat_we    (beat_we_s),
    .last_beat  (last_beat_s),
    .inval_all  (inval_all_s),
    .rom_req    (rom_req_o),
    .rom_addr   (rom_addr_o)
  );

  // IF may proceed only in IDLE without a fence, when idle or hitting.
  always_comb begin
    icache_ready_o = 1'b0;
    if (rst)                        icache_ready_o = 1'b0;
    else if (idle_s && !fence_i_i)  icache_ready_o = !fetch_req_i || hit_s;
    else                            icache_ready_o = 1'b0;
  end

  // Zero-latency read of the addressed word; forced to zero during reset.
  always_comb begin
    inst_o = 32'd0;
    if (rst) inst_o = 32'd0;
    else     inst_o = data_r[idx_s][off_s];
  end

  // Valid bits: fence clears all, a miss drops its line, the last beat revalidates it.
  always_ff @(posedge clk) begin
    if (rst)                            valid_r <= '0;
    else if (inval_all_s)               valid_r <= '0;
    else if (miss_s)                    valid_r[idx_s] <= 1'b0;
    else if (beat_we_s && last_beat_s)  valid_r[rf_idx_s] <= 1'b1;
  end

  // Tag is written together with the final beat of the line.
  always_ff @(posedge clk) begin
    if (beat_we_s && last_beat_s) tag_r[rf_idx_s] <= rf_tag_s;
  end

  // Each accepted ROM beat lands in the line being refilled.
  always_ff @(posedge clk) begin
    if (beat_we_s) data_r[rf_idx_s][beat_s] <= rom_data_i;
  end

`ifdef ICACHE_PERF_EN
  // Hit/miss event counters, sampled once per IDLE fetch cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_o  <= 32'd0;
      perf_miss_o <= 32'd0;
    end else if (idle_s && fetch_req_i) begin
      if (hit_s) perf_hit_o  <= perf_hit_o + 32'd1;
      else       perf_miss_o <= perf_miss_o + 32'd1;
    end
  end
`endif

endmodule
